alu_ctrl: RTL and testbench

Instruction sequencer directly upstream of the 8-bit ALU `one`. It accepts 16-bit instructions over a valid/ready handshake and reads operands from a 4×8-bit register file. It drives `A`/`B`/`Opcode` into the ALU and writes `Result`, `Zero` and `CarryOut` back into the register file and a flag register. Together, `alu_ctrl` and `one` form the project's minimal datapath core.

---
 rtl/arihant_pkg.sv | 47 ++++
 rtl/regfile4x8.sv | 35 +++
 rtl/alu_ctrl.sv | 114 +++++++++++
 tb/tb_alu_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arihant_pkg.sv
// Shared definitions for the alu_ctrl sequencer: opcodes, instruction field
// positions, FSM encoding and opcode classification helpers.
package arihant_pkg;

    localparam int DW    = 8;
    localparam int RW    = 2;
    localparam int NREGS = 4;
    localparam int OPW   = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB = 4'b0001;
    localparam logic [OPW-1:0] OP_AND = 4'b0010;
    localparam logic [OPW-1:0] OP_OR  = 4'b0011;
    localparam logic [OPW-1:0] OP_XOR = 4'b0100;
    localparam logic [OPW-1:0] OP_NOT = 4'b0101;
    localparam logic [OPW-1:0] OP_SLL = 4'b0110;
    localparam logic [OPW-1:0] OP_LDI = 4'b1000;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SLL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        return is_alu_op(op) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: one synchronous write port, three combinational reads
// (two operand ports and a debug port).
module regfile4x8
    import arihant_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_rs1,
    input  logic [RW-1:0] raddr_rs2,
    input  logic [RW-1:0] raddr_dbg,
    output logic [DW-1:0] rdata_rs1,
    output logic [DW-1:0] rdata_rs2,
    output logic [DW-1:0] rdata_dbg
);

    logic [DW-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_rs1 = mem_q[raddr_rs1];
    assign rdata_rs2 = mem_q[raddr_rs2];
    assign rdata_dbg = mem_q[raddr_dbg];

endmodule

// File: rtl/alu_ctrl.sv
// Three-state instruction sequencer feeding an external 8-bit ALU and writing
// its result and flags back into a 4x8 register file.
module alu_ctrl
    import arihant_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [15:0]    instr,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero,
    input  logic           alu_carry,
    input  logic [RW-1:0]  dbg_sel,
    output logic [DW-1:0]  dbg_data,
    output logic           flag_z,
    output logic           flag_c,
    output logic           done,
    output logic           err
);

    state_e         state_q;
    logic [OPW-1:0] op_q;
    logic [RW-1:0]  rd_q;
    logic [DW-1:0]  imm_q;
    logic [DW-1:0]  alu_a_q, alu_b_q;
    logic [OPW-1:0] alu_op_q;
    logic           flag_z_q, flag_c_q, done_q, err_q;

    logic [OPW-1:0] instr_op;
    logic [DW-1:0]  rs1_data, rs2_data;
    logic           wr_en;
    logic [DW-1:0]  wr_data;

    assign instr_op = instr[OP_MSB:OP_LSB];

    // Writeback happens on the edge that leaves EXEC; illegal ops never write.
    assign wr_en   = (state_q == ST_EXEC) && is_legal_op(op_q);
    assign wr_data = (op_q == OP_LDI) ? imm_q : alu_result;

    regfile4x8 u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wr_en),
        .waddr     (rd_q),
        .wdata     (wr_data),
        .raddr_rs1 (instr[RS1_MSB:RS1_LSB]),
        .raddr_rs2 (instr[RS2_MSB:RS2_LSB]),
        .raddr_dbg (dbg_sel),
        .rdata_rs1 (rs1_data),
        .rdata_rs2 (rs2_data),
        .rdata_dbg (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            imm_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_ADD;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rd_q  <= instr[RD_MSB:RD_LSB];
                        imm_q <= instr[IMM_MSB:IMM_LSB];
                        if (is_alu_op(instr_op)) begin
                            alu_a_q  <= rs1_data;
                            alu_b_q  <= rs2_data;
                            alu_op_q <= instr_op;
                        end
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_alu_op(op_q)) begin
                        flag_z_q <= alu_zero;
                        flag_c_q <= alu_carry;
                    end
                    done_q  <= 1'b1;
                    err_q   <= !is_legal_op(op_q);
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: a behavioural ALU stands in for `one`, a
// register-file model predicts each retirement, and a monitor checks on done.
`timescale 1ns/1ps
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero, alu_carry;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic        flag_z, flag_c, done, err;

    logic        stim_owns_dbg;
    logic [1:0]  stim_sel, mon_sel;
    assign dbg_sel = stim_owns_dbg ? stim_sel : mon_sel;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Behavioural ALU: {carry, result}; SUB carry is the 9th bit of a-b (borrow).
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] sh;
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {1'b0, a} - {1'b0, b};
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, ~a};
            4'd6: begin
                sh = {8'h00, a} << b;
                return {1'b0, sh[7:0]};
            end
            default: return 9'h000;
        endcase
    endfunction

    logic [8:0] alu_out;
    always_comb alu_out = alu_ref(alu_op, alu_a, alu_b);
    assign alu_result = alu_out[7:0];
    assign alu_carry  = alu_out[8];
    assign alu_zero   = (alu_out[7:0] == 8'h00);

    alu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic       err;
        logic [1:0] rd;
        logic [7:0] val;
        logic       fz, fc;
        logic [3:0] op;
        logic [7:0] a, b;
        int         hs;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] m_reg [4];
    logic       m_fz, m_fc;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_fz = 1'b0; m_fc = 1'b0; m_op = 4'h0; m_a = 8'h00; m_b = 8'h00;
    endtask

    task automatic model_issue(input logic [15:0] ins, input int hs);
        logic [3:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [8:0] r;
        exp_t       e;
        op = ins[15:12]; rd = ins[11:10]; rs1 = ins[9:8]; rs2 = ins[7:6];
        if (op <= 4'd6) begin
            r      = alu_ref(op, m_reg[rs1], m_reg[rs2]);
            m_op   = op;
            m_a    = m_reg[rs1];
            m_b    = m_reg[rs2];
            m_reg[rd] = r[7:0];
            m_fz   = (r[7:0] == 8'h00);
            m_fc   = r[8];
        end else if (op == 4'd8) begin
            m_reg[rd] = ins[7:0];
        end
        e.err = !(op <= 4'd6 || op == 4'd8);
        e.rd  = rd;  e.val = m_reg[rd];
        e.fz  = m_fz; e.fc = m_fc;
        e.op  = m_op; e.a  = m_a; e.b = m_b;
        e.hs  = hs;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] alu_ins(input logic [3:0] op, input logic [1:0] rd,
                                            input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 6'b000000};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'h8, rd, 2'b00, imm};
    endfunction

    // Called at a negedge; returns at the negedge inside EXEC with valid still high.
    task automatic issue(input logic [15:0] ins);
        int waited;
        waited = 0;
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            check("handshake_timeout", {31'b0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        model_issue(ins, cyc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        stim_owns_dbg = 1'b1;
        for (int r = 0; r < 4; r++) begin
            stim_sel = r[1:0];
            #1;
            check({tag, "_reg"}, {24'b0, dbg_data}, 32'h0);
        end
        check({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
        check({tag, "_done"},  {31'b0, done}, 32'd0);
        check({tag, "_err"},   {31'b0, err}, 32'd0);
        check({tag, "_flags"}, {30'b0, flag_z, flag_c}, 32'd0);
        check({tag, "_alu"},   {12'b0, alu_op, alu_a, alu_b}, 32'd0);
        stim_owns_dbg = 1'b0;
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin : monitor
        exp_t e;
        mon_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    check("done_without_instr", {31'b0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    mon_sel = e.rd;
                    #1;
                    check("latency", cyc, e.hs + 2);
                    check("err",     {31'b0, err}, {31'b0, e.err});
                    check("rd_value",{24'b0, dbg_data}, {24'b0, e.val});
                    check("flag_z",  {31'b0, flag_z}, {31'b0, e.fz});
                    check("flag_c",  {31'b0, flag_c}, {31'b0, e.fc});
                    check("alu_op",  {28'b0, alu_op}, {28'b0, e.op});
                    check("alu_ab",  {16'b0, alu_a, alu_b}, {16'b0, e.a, e.b});
                    $display("retire cyc=%0d err=%0d r%0d=%02h z=%0d c=%0d",
                             cyc, err, e.rd, dbg_data, flag_z, flag_c);
                end
            end
        end
    end

    initial begin : stimulus
        int low;
        int waited;
        int ill_list[8];
        logic [3:0] op;
        int pick;
        ill_list = '{7, 9, 10, 11, 12, 13, 14, 15};

        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0;
        stim_owns_dbg = 1'b1; stim_sel = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ADD
        issue(ldi(2'd0, 8'd5)); issue(ldi(2'd1, 8'd3));
        issue(alu_ins(4'd0, 2'd2, 2'd0, 2'd1)); idle(3);
        // Overflow
        issue(ldi(2'd0, 8'd255)); issue(ldi(2'd1, 8'd1));
        issue(alu_ins(4'd0, 2'd3, 2'd0, 2'd1)); idle(3);
        // SUB with borrow
        issue(ldi(2'd0, 8'd5)); issue(ldi(2'd1, 8'd8));
        issue(alu_ins(4'd1, 2'd2, 2'd0, 2'd1)); idle(3);
        // Logic ops, NOT, SLL, then LDI keeping flags
        issue(ldi(2'd0, 8'hAA)); issue(ldi(2'd1, 8'h55));
        issue(alu_ins(4'd2, 2'd2, 2'd0, 2'd1));
        issue(alu_ins(4'd3, 2'd2, 2'd0, 2'd1));
        issue(alu_ins(4'd4, 2'd2, 2'd0, 2'd1));
        issue(alu_ins(4'd5, 2'd2, 2'd0, 2'd1));
        issue(ldi(2'd1, 8'd7));
        issue(ldi(2'd1, 8'd2));
        issue(alu_ins(4'd6, 2'd3, 2'd0, 2'd1));
        issue(ldi(2'd2, 8'h00)); idle(3);

        // Illegal opcode: ready must stay low for exactly two sampled cycles
        issue(alu_ins(4'hA, 2'd0, 2'd1, 2'd2));
        instr_valid = 1'b0;
        low = instr_ready ? 0 : 1;
        waited = 0;
        while (!instr_ready && waited < 10) begin
            @(negedge clk);
            waited++;
            if (!instr_ready) low++;
        end
        check("illegal_ready_low", low, 2);
        idle(2);

        // Reset during EXEC aborts the ADD
        issue(ldi(2'd0, 8'd9)); idle(1);
        issue(alu_ins(4'd0, 2'd2, 2'd0, 2'd0));
        instr_valid = 1'b0;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("midreset");
        rst_n = 1'b1;
        issue(ldi(2'd1, 8'h3C));
        issue(alu_ins(4'd0, 2'd2, 2'd1, 2'd1)); idle(3);

        // Randomized traffic, including back-to-back presentation
        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 6)      op = pick[3:0];
            else if (pick <= 8) op = 4'h8;
            else                op = ill_list[$urandom_range(0, 7)][3:0];
            if (op == 4'h8) issue(ldi(2'($urandom_range(0, 3)), 8'($urandom)));
            else issue(alu_ins(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                               2'($urandom_range(0, 3))));
            pick = $urandom_range(0, 2);
            if (pick != 0) idle(pick);
        end
        idle(1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
